cpu_run_ctrl: RTL

- Execution controller that sequences the pipelined CPU on behalf of the serial debug unit.
- Turns debug commands (stop, step N, run, run-to-breakpoint) into a per-cycle CPU clock enable.
- Holds a small PC breakpoint table and counts executed CPU cycles.
- Sits between the debug unit command interface and the CPU clock-enable input, on the same clock as the debug unit.

---
 rtl/cpu_run_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl -- execution controller between the serial debug unit and
// the pipelined CPU. Debug commands (stop, step N, run, run-to-breakpoint)
// become a per-cycle CPU clock enable. The block also keeps a small PC
// breakpoint table and counts executed CPU cycles.
//
// Optional build macro: RUN_TIMEOUT_EN. When defined, RUN and RUN_BP stop
// after TIMEOUT enable pulses with halt_reason 3. When undefined, there is
// no timeout counter.
//
// Ports:
//   clk          system clock; all logic on the rising edge
//   rst          synchronous, active-high reset
//   cmd_valid    command present this cycle; always accepted (no ready)
//   cmd_op       0 NOP, 1 STOP, 2 STEP, 3 RUN, 4 RUN_BP, 5 SET_BP,
//                6 CLR_BP, 7 CLR_ALL
//   cmd_arg      STEP cycle count / SET_BP breakpoint PC
//   bp_sel       breakpoint entry index for SET_BP / CLR_BP
//   pc           CPU IF-stage pc; updates the cycle after each enable pulse
//   cpu_clk_en   CPU advances one cycle when high (combinational)
//   halted       high while idle
//   halt_reason  0 step done, 1 stop, 2 breakpoint, 3 timeout
//   cycle_cnt    total cpu_clk_en pulses since reset (wraps)
//   cmd_err      one-cycle pulse the cycle after a command is rejected
//   dbg_state    current FSM state (0 IDLE, 1 STEP, 2 RUN, 3 RUN_BP)
//
// Command handshake: valid-only. A command is taken in every cycle where
// cmd_valid is high; there is no ready, so the debug unit must not hold a
// command for more than one cycle unless it means to issue it again.
module cpu_run_ctrl #(
    parameter int NUM_BP  = 4,
    parameter int TIMEOUT = 1000000,
    localparam int SEL_W  = $clog2(NUM_BP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd_op,
    input  logic [31:0]      cmd_arg,
    input  logic [SEL_W-1:0] bp_sel,
    input  logic [31:0]      pc,
    output logic             cpu_clk_en,
    output logic             halted,
    output logic [1:0]       halt_reason,
    output logic [31:0]      cycle_cnt,
    output logic             cmd_err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_RUN    = 2'd2,
        S_RUN_BP = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_STOP    = 3'd1;
    localparam logic [2:0] OP_STEP    = 3'd2;
    localparam logic [2:0] OP_RUN     = 3'd3;
    localparam logic [2:0] OP_RUN_BP  = 3'd4;
    localparam logic [2:0] OP_SET_BP  = 3'd5;
    localparam logic [2:0] OP_CLR_BP  = 3'd6;
    localparam logic [2:0] OP_CLR_ALL = 3'd7;

    state_t      state, state_n;
    logic [1:0]  reason_n;
    logic [31:0] step_cnt, step_n;
    logic        first_cyc, first_n;
    logic        err_n;
    logic        stop_acc, bp_match, bp_hit, idle_cmd;

    logic [NUM_BP-1:0] bp_valid;
    logic [31:0]       bp_pc [NUM_BP];

`ifdef RUN_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
    logic [31:0] tmo_cnt, tmo_n;
`endif

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        reason_n = halt_reason;
        step_n   = step_cnt;
        first_n  = 1'b0;
        err_n    = 1'b0;
        bp_match = 1'b0;
`ifdef RUN_TIMEOUT_EN
        tmo_n    = tmo_cnt;
`endif

        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_valid[i] && (bp_pc[i] == pc)) bp_match = 1'b1;
        end

        stop_acc = cmd_valid && (cmd_op == OP_STOP);
        idle_cmd = cmd_valid && (state == S_IDLE);
        // The first RUN_BP cycle ignores the table so a run can resume
        // from the PC it last stopped on.
        bp_hit   = (state == S_RUN_BP) && !first_cyc && bp_match;
        cpu_clk_en = (state != S_IDLE) && !stop_acc && !bp_hit && !rst;

        if (state == S_IDLE) begin
            if (cmd_valid) begin
                case (cmd_op)
                    OP_STEP: begin
                        state_n = S_STEP;
                        step_n  = (cmd_arg == 32'd0) ? 32'd1 : cmd_arg;
                    end
                    OP_RUN: begin
                        state_n = S_RUN;
`ifdef RUN_TIMEOUT_EN
                        tmo_n   = 32'd0;
`endif
                    end
                    OP_RUN_BP: begin
                        state_n = S_RUN_BP;
                        first_n = 1'b1;
`ifdef RUN_TIMEOUT_EN
                        tmo_n   = 32'd0;
`endif
                    end
                    default: ;
                endcase
            end
        end else begin
            err_n = cmd_valid && (cmd_op != OP_NOP) && (cmd_op != OP_STOP);
            if (stop_acc) begin
                // STOP wins even on the last STEP pulse.
                state_n  = S_IDLE;
                reason_n = 2'd1;
            end else if (bp_hit) begin
                state_n  = S_IDLE;
                reason_n = 2'd2;
            end else if (state == S_STEP) begin
                step_n = step_cnt - 32'd1;
                if (step_cnt == 32'd1) begin
                    state_n  = S_IDLE;
                    reason_n = 2'd0;
                end
            end else begin
`ifdef RUN_TIMEOUT_EN
                // A pulse is issued this cycle; this is pulse tmo_cnt+1.
                tmo_n = tmo_cnt + 32'd1;
                if (tmo_cnt == TMO_LAST) begin
                    state_n  = S_IDLE;
                    reason_n = 2'd3;
                end
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            halt_reason <= 2'd0;
            step_cnt    <= 32'd0;
            first_cyc   <= 1'b0;
            cmd_err     <= 1'b0;
            cycle_cnt   <= 32'd0;
`ifdef RUN_TIMEOUT_EN
            tmo_cnt     <= 32'd0;
`endif
        end else begin
            state       <= state_n;
            halt_reason <= reason_n;
            step_cnt    <= step_n;
            first_cyc   <= first_n;
            cmd_err     <= err_n;
            if (cpu_clk_en) cycle_cnt <= cycle_cnt + 32'd1;
`ifdef RUN_TIMEOUT_EN
            tmo_cnt     <= tmo_n;
`endif
        end
    end

    // Breakpoint table; only edited while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_valid <= '0;
            for (int i = 0; i < NUM_BP; i++) bp_pc[i] <= 32'd0;
        end else if (idle_cmd) begin
            case (cmd_op)
                OP_SET_BP: begin
                    bp_valid[bp_sel] <= 1'b1;
                    bp_pc[bp_sel]    <= cmd_arg;
                end
                OP_CLR_BP:  bp_valid[bp_sel] <= 1'b0;
                OP_CLR_ALL: bp_valid <= '0;
                default: ;
            endcase
        end
    end

    assign halted    = (state == S_IDLE);
    assign dbg_state = state;

endmodule
